// File: rtl/cv32e40p_wb_arbiter.sv
// Writeback arbiter in front of the register file write port: merges EX results and
// load responses into one registered write per cycle, with a one-entry EX skid buffer.
module cv32e40p_wb_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid_i,
    output logic                  ex_ready_o,
    input  logic [4:0]            ex_waddr_i,
    input  logic [DATA_WIDTH-1:0] ex_wdata_i,
    input  logic                  lsu_valid_i,
    input  logic [4:0]            lsu_waddr_i,
    input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
    input  logic                  lsu_issue_i,
    input  logic [4:0]            lsu_issue_addr_i,
    output logic                  rf_we_o,
    output logic [4:0]            rf_waddr_o,
    output logic [DATA_WIDTH-1:0] rf_wdata_o,
    output logic [31:0]           busy_o
);

    logic                  buf_valid;
    logic [4:0]            buf_addr;
    logic [DATA_WIDTH-1:0] buf_data;
    logic [31:1]           busy_q;

    logic                  ex_xfer;
    logic                  sel_valid;
    logic [4:0]            sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [31:0]           busy_set;
    logic [31:0]           busy_clr;

    // Readiness depends only on the buffer, so there is no input-to-ready path.
    assign ex_ready_o = !buf_valid;
    assign ex_xfer    = ex_valid_i && ex_ready_o;

    // Loads are always older than a competing EX result, so they win the port.
    always_comb begin
        sel_valid = 1'b0;
        sel_addr  = ex_waddr_i;
        sel_data  = ex_wdata_i;
        if (lsu_valid_i) begin
            sel_valid = 1'b1;
            sel_addr  = lsu_waddr_i;
            sel_data  = lsu_wdata_i;
        end else if (buf_valid) begin
            sel_valid = 1'b1;
            sel_addr  = buf_addr;
            sel_data  = buf_data;
        end else if (ex_xfer) begin
            sel_valid = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid  <= 1'b0;
            buf_addr   <= 5'd0;
            buf_data   <= '0;
            rf_we_o    <= 1'b0;
            rf_waddr_o <= 5'd0;
            rf_wdata_o <= '0;
        end else begin
            if (lsu_valid_i) begin
                if (ex_xfer) begin
                    buf_valid <= 1'b1;
                    buf_addr  <= ex_waddr_i;
                    buf_data  <= ex_wdata_i;
                end
            end else if (buf_valid) begin
                buf_valid <= 1'b0;
            end

            // Writes to x0 are consumed but never enabled at the register file.
            rf_we_o <= sel_valid && (sel_addr != 5'd0);
            if (sel_valid) begin
                rf_waddr_o <= sel_addr;
                rf_wdata_o <= sel_data;
            end
        end
    end

    always_comb begin
        busy_set = 32'd0;
        busy_clr = 32'd0;
        if (lsu_issue_i) busy_set = 32'd1 << lsu_issue_addr_i;
        if (lsu_valid_i) busy_clr = 32'd1 << lsu_waddr_i;
    end

    // Set wins over clear so a re-issue in the response cycle keeps the bit busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= (busy_q & ~busy_clr[31:1]) | busy_set[31:1];
        end
    end

    assign busy_o = {busy_q, 1'b0};

endmodule

// File: tb/tb_cv32e40p_wb_arbiter.sv
// Directed bench for cv32e40p_wb_arbiter: hand-computed expectations for
// priority, skid buffering, x0 handling, scoreboard and mid-operation reset.
module tb_cv32e40p_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        ex_valid_i;
    logic        ex_ready_o;
    logic [4:0]  ex_waddr_i;
    logic [31:0] ex_wdata_i;
    logic        lsu_valid_i;
    logic [4:0]  lsu_waddr_i;
    logic [31:0] lsu_wdata_i;
    logic        lsu_issue_i;
    logic [4:0]  lsu_issue_addr_i;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic [31:0] busy_o;

    int total = 0;
    int bad   = 0;
    logic [31:0] rf_model [32];

    cv32e40p_wb_arbiter #(.DATA_WIDTH(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ex_valid_i       (ex_valid_i),
        .ex_ready_o       (ex_ready_o),
        .ex_waddr_i       (ex_waddr_i),
        .ex_wdata_i       (ex_wdata_i),
        .lsu_valid_i      (lsu_valid_i),
        .lsu_waddr_i      (lsu_waddr_i),
        .lsu_wdata_i      (lsu_wdata_i),
        .lsu_issue_i      (lsu_issue_i),
        .lsu_issue_addr_i (lsu_issue_addr_i),
        .rf_we_o          (rf_we_o),
        .rf_waddr_o       (rf_waddr_o),
        .rf_wdata_o       (rf_wdata_o),
        .busy_o           (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file behind the write port.
    always @(posedge clk) begin
        if (rf_we_o) rf_model[rf_waddr_o] <= rf_wdata_o;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid_i  = 1'b0;
        lsu_valid_i = 1'b0;
        lsu_issue_i = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf_model[i] = 32'd0;
        rst_n            = 1'b0;
        ex_valid_i       = 1'b0;
        ex_waddr_i       = 5'd0;
        ex_wdata_i       = 32'd0;
        lsu_valid_i      = 1'b0;
        lsu_waddr_i      = 5'd0;
        lsu_wdata_i      = 32'd0;
        lsu_issue_i      = 1'b0;
        lsu_issue_addr_i = 5'd0;
        step();
        step();
        chk("rst_we", {31'd0, rf_we_o}, 32'd0);
        chk("rst_waddr", {27'd0, rf_waddr_o}, 32'd0);
        chk("rst_wdata", rf_wdata_o, 32'd0);
        chk("rst_busy", busy_o, 32'd0);
        chk("rst_ready", {31'd0, ex_ready_o}, 32'd1);
        rst_n = 1'b1;
        step();

        // EX only
        ex_valid_i = 1'b1; ex_waddr_i = 5'd5; ex_wdata_i = 32'h1234;
        step();
        idle_inputs();
        chk("ex_we", {31'd0, rf_we_o}, 32'd1);
        chk("ex_waddr", {27'd0, rf_waddr_o}, 32'd5);
        chk("ex_wdata", rf_wdata_o, 32'h1234);
        chk("ex_ready", {31'd0, ex_ready_o}, 32'd1);
        step();
        chk("idle_we", {31'd0, rf_we_o}, 32'd0);
        chk("idle_hold_addr", {27'd0, rf_waddr_o}, 32'd5);
        chk("idle_hold_data", rf_wdata_o, 32'h1234);

        // Collision
        ex_valid_i = 1'b1; ex_waddr_i = 5'd3; ex_wdata_i = 32'hAAAA;
        lsu_valid_i = 1'b1; lsu_waddr_i = 5'd7; lsu_wdata_i = 32'hBBBB;
        step();
        idle_inputs();
        chk("col1_we", {31'd0, rf_we_o}, 32'd1);
        chk("col1_waddr", {27'd0, rf_waddr_o}, 32'd7);
        chk("col1_wdata", rf_wdata_o, 32'hBBBB);
        chk("col1_ready", {31'd0, ex_ready_o}, 32'd0);
        step();
        chk("col2_we", {31'd0, rf_we_o}, 32'd1);
        chk("col2_waddr", {27'd0, rf_waddr_o}, 32'd3);
        chk("col2_wdata", rf_wdata_o, 32'hAAAA);
        chk("col2_ready", {31'd0, ex_ready_o}, 32'd1);
        step();
        chk("col3_we", {31'd0, rf_we_o}, 32'd0);

        // Same-register ordering
        ex_valid_i = 1'b1; ex_waddr_i = 5'd9; ex_wdata_i = 32'h2;
        lsu_valid_i = 1'b1; lsu_waddr_i = 5'd9; lsu_wdata_i = 32'h1;
        step();
        idle_inputs();
        chk("ord1_wdata", rf_wdata_o, 32'h1);
        step();
        chk("ord2_waddr", {27'd0, rf_waddr_o}, 32'd9);
        chk("ord2_wdata", rf_wdata_o, 32'h2);
        step();
        chk("ord_final_x9", rf_model[9], 32'h2);

        // LSU stream starvation
        ex_valid_i = 1'b1; ex_waddr_i = 5'd11; ex_wdata_i = 32'h55;
        lsu_valid_i = 1'b1; lsu_waddr_i = 5'd12; lsu_wdata_i = 32'h100;
        step();
        ex_valid_i = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            lsu_wdata_i = 32'h100 + c;
            chk($sformatf("starve_ready_c%0d", c), {31'd0, ex_ready_o}, 32'd0);
            chk($sformatf("starve_data_c%0d", c), rf_wdata_o, 32'h100 + c - 1);
            step();
        end
        lsu_valid_i = 1'b0;
        chk("starve_ready_c4", {31'd0, ex_ready_o}, 32'd0);
        chk("starve_data_c4", rf_wdata_o, 32'h103);
        step();
        chk("starve_buf_we", {31'd0, rf_we_o}, 32'd1);
        chk("starve_buf_waddr", {27'd0, rf_waddr_o}, 32'd11);
        chk("starve_buf_wdata", rf_wdata_o, 32'h55);
        chk("starve_ready_c5", {31'd0, ex_ready_o}, 32'd1);

        // x0
        ex_valid_i = 1'b1; ex_waddr_i = 5'd0; ex_wdata_i = 32'hDEAD;
        step();
        idle_inputs();
        chk("x0_we", {31'd0, rf_we_o}, 32'd0);
        chk("x0_ready", {31'd0, ex_ready_o}, 32'd1);
        lsu_issue_i = 1'b1; lsu_issue_addr_i = 5'd0;
        step();
        idle_inputs();
        chk("x0_busy", busy_o, 32'd0);

        // Scoreboard
        lsu_issue_i = 1'b1; lsu_issue_addr_i = 5'd4;
        step();
        idle_inputs();
        chk("sb_set4", busy_o, 32'h10);
        lsu_issue_i = 1'b1; lsu_issue_addr_i = 5'd6;
        step();
        idle_inputs();
        chk("sb_set6", busy_o, 32'h50);
        lsu_valid_i = 1'b1; lsu_waddr_i = 5'd4; lsu_wdata_i = 32'h44;
        lsu_issue_i = 1'b1; lsu_issue_addr_i = 5'd4;
        step();
        idle_inputs();
        chk("sb_set_wins", busy_o, 32'h50);
        lsu_valid_i = 1'b1; lsu_waddr_i = 5'd4;
        step();
        idle_inputs();
        chk("sb_clr4", busy_o, 32'h40);
        lsu_valid_i = 1'b1; lsu_waddr_i = 5'd6;
        step();
        idle_inputs();
        chk("sb_clr6", busy_o, 32'h0);

        // Reset while the skid buffer holds a result
        ex_valid_i = 1'b1; ex_waddr_i = 5'd13; ex_wdata_i = 32'h77;
        lsu_valid_i = 1'b1; lsu_waddr_i = 5'd14; lsu_wdata_i = 32'h88;
        lsu_issue_i = 1'b1; lsu_issue_addr_i = 5'd2;
        step();
        idle_inputs();
        chk("mid_pre_ready", {31'd0, ex_ready_o}, 32'd0);
        chk("mid_pre_busy", busy_o, 32'h4);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we", {31'd0, rf_we_o}, 32'd0);
        chk("mid_rst_busy", busy_o, 32'd0);
        chk("mid_rst_ready", {31'd0, ex_ready_o}, 32'd1);
        chk("mid_rst_waddr", {27'd0, rf_waddr_o}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_we1", {31'd0, rf_we_o}, 32'd0);
        step();
        chk("post_rst_we2", {31'd0, rf_we_o}, 32'd0);
        chk("post_rst_x13", rf_model[13], 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
